int_sequencer: RTL

//   CPU-side responder to the interrupt coprocessor. Consumes int/ints/irs, and at an instruction

---
 rtl/int_sequencer_pkg.sv | 34 +++
 rtl/int_sequencer_if.sv | 36 +++
 rtl/int_prio_enc.sv | 17 +
 rtl/int_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
// Shared core header: sequencer state encoding, vector defaults and the
// ints/level encoding used by both the CPU side and the interrupt coprocessor.
package int_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENT_SAVE = 3'd1,
    ST_ENT_MARK = 3'd2,
    ST_ENT_JUMP = 3'd3,
    ST_EX_CLR   = 3'd4,
    ST_EX_JUMP  = 3'd5
  } seq_state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0080;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0020;

  // ints: 0 means nothing pending, 1..3 is the highest pending level
  localparam logic [2:0] INTS_NONE = 3'd0;

  typedef logic [1:0] lvl_t;

  // One-hot in-service bit for a level; level 0 maps to no bit
  function automatic logic [2:0] lvl_onehot(input lvl_t lvl);
    logic [2:0] oh;
    case (lvl)
      2'd1:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd3:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Coprocessor/pipeline bus of the interrupt sequencer. The slave modport is
// the sequencer itself; the master modport is whoever drives the requests.
interface int_sequencer_if;

  logic        int_req;
  logic [2:0]  ints;
  logic [2:0]  irs;
  logic [31:0] epc;
  logic        boundary;
  logic [31:0] resume_pc;
  logic        eret;

  logic        stall;
  logic        redirect;
  logic [31:0] pc_target;
  logic        epc_w_en;
  logic [31:0] epc_w_data;
  logic        ie_w_en;
  logic        ie_w_data;
  logic        irs_set_en;
  logic        irs_clr_en;
  logic [2:0]  irs_w_mask;

  modport slave (
    input  int_req, ints, irs, epc, boundary, resume_pc, eret,
    output stall, redirect, pc_target, epc_w_en, epc_w_data,
           ie_w_en, ie_w_data, irs_set_en, irs_clr_en, irs_w_mask
  );

  modport master (
    output int_req, ints, irs, epc, boundary, resume_pc, eret,
    input  stall, redirect, pc_target, epc_w_en, epc_w_data,
           ie_w_en, ie_w_data, irs_set_en, irs_clr_en, irs_w_mask
  );

endinterface

// File: rtl/int_prio_enc.sv
// Priority encoder over the in-service bits: highest set bit wins, 0 if none.
module int_prio_enc
  import int_sequencer_pkg::*;
(
  input  logic [2:0] irs_i,
  output lvl_t       lvl_o
);

  // Highest in-service level
  always_comb begin
    lvl_o = 2'd0;
    if (irs_i[2])      lvl_o = 2'd3;
    else if (irs_i[1]) lvl_o = 2'd2;
    else if (irs_i[0]) lvl_o = 2'd1;
  end

endmodule

// File: rtl/int_sequencer.sv
// CPU-side interrupt entry/exit sequencer. Accepts a request or ERET at an
// instruction boundary, stalls the pipeline, drives coprocessor write strobes
// and finally redirects the PC. Outputs are decoded from registered state only.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  int_sequencer_if.slave bus
);

  seq_state_t  state_q, state_d;
  lvl_t        lvl_q, lvl_d;
  logic [31:0] tgt_q, tgt_d;
  lvl_t        irs_lvl;
  logic [31:0] vec_addr;

  int_prio_enc u_prio_enc (
    .irs_i (bus.irs),
    .lvl_o (irs_lvl)
  );

  assign vec_addr = VEC_BASE + ((32'(lvl_q) - 32'd1) * VEC_STRIDE);

  // State, level and target registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    state_d        = state_q;
    lvl_d          = lvl_q;
    tgt_d          = tgt_q;
    bus.stall      = 1'b1;
    bus.redirect   = 1'b0;
    bus.pc_target  = '0;
    bus.epc_w_en   = 1'b0;
    bus.epc_w_data = '0;
    bus.ie_w_en    = 1'b0;
    bus.ie_w_data  = 1'b0;
    bus.irs_set_en = 1'b0;
    bus.irs_clr_en = 1'b0;
    bus.irs_w_mask = '0;

    case (state_q)
      ST_IDLE: begin
        bus.stall = 1'b0;
        if (bus.boundary && bus.eret) begin
          state_d = ST_EX_CLR;
          lvl_d   = irs_lvl;
        end else if (bus.boundary && bus.int_req && (bus.ints != INTS_NONE)) begin
          state_d = ST_ENT_SAVE;
          lvl_d   = bus.ints[1:0];
          tgt_d   = bus.resume_pc;
        end
      end
      ST_ENT_SAVE: begin
        bus.epc_w_en   = 1'b1;
        bus.epc_w_data = tgt_q;
        bus.ie_w_en    = 1'b1;
        bus.ie_w_data  = 1'b0;
        state_d        = ST_ENT_MARK;
      end
      ST_ENT_MARK: begin
        bus.irs_set_en = 1'b1;
        bus.irs_w_mask = lvl_onehot(lvl_q);
        state_d        = ST_ENT_JUMP;
      end
      ST_ENT_JUMP: begin
        bus.redirect  = 1'b1;
        bus.pc_target = vec_addr;
        state_d       = ST_IDLE;
      end
      ST_EX_CLR: begin
        // ERET with nothing in service still restores IE and returns to EPC
        if (lvl_q != 2'd0) begin
          bus.irs_clr_en = 1'b1;
          bus.irs_w_mask = ~lvl_onehot(lvl_q);
        end
        bus.ie_w_en   = 1'b1;
        bus.ie_w_data = 1'b1;
        tgt_d         = bus.epc;
        state_d       = ST_EX_JUMP;
      end
      ST_EX_JUMP: begin
        bus.redirect  = 1'b1;
        bus.pc_target = tgt_q;
        state_d       = ST_IDLE;
      end
      default: begin
        bus.stall = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

endmodule
